vga_timing_gen: RTL and testbench

//  Display timing generator: raster counters, H/V sync and video_on for the VGA path.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_pix_tick.sv | 45 ++++
 rtl/vga_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared constants and types for the VGA timing generator.
//                640x480@60 timing values with derived line/frame totals,
//                the 12-bit raster coordinate type and sync polarity codes.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    // 640x480@60 horizontal timing, in pixels
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    // 640x480@60 vertical timing, in lines
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // 100 MHz system clock divided down to a 25 MHz pixel rate
    localparam int unsigned VGA_CLK_DIV    = 4;
    localparam int unsigned VGA_SYNC_DELAY = 2;

    // Raster coordinate as seen by the icon / world-map lookups
    typedef logic [11:0] coord_t;

    // Asserted level of horiz_sync / vert_sync
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_pix_tick.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pix_tick
//  Description : Pixel-rate divider. A counter runs 0..CLK_DIV-1 and wraps;
//                o_tick is high while the counter sits at CLK_DIV-1. With
//                CLK_DIV==1 the tick is high on every clock outside reset.
//  Ports       : clk    in  system clock
//                rst    in  synchronous active-high reset
//                o_tick out one-clock strobe per pixel period
//  Revision    : 1.0  initial release
// ============================================================================
module vga_pix_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    generate
        if (CLK_DIV <= 1) begin : g_div_bypass
            // No divider state: every clock is a pixel.
            assign o_tick = ~rst;
        end else begin : g_div_count
            localparam int unsigned DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

            logic [DIV_W-1:0] r_div;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_div <= '0;
                end else if (r_div == C_DIV_LAST) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign o_tick = (r_div == C_DIV_LAST) && !rst;
        end
    endgenerate

endmodule : vga_pix_tick
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Display timing generator. Raster counters advance once per
//                pixel tick; every output is a registered decode of the
//                counters, one clock behind them.
//  Ports       : clock        in   system clock
//                reset        in   synchronous active-high reset
//                horiz_sync   out  horizontal sync (asserted level SYNC_POL)
//                vert_sync    out  vertical sync   (asserted level SYNC_POL)
//                video_on     out  current pixel lies in the active region
//                pixel_row    out  12-bit line counter, 0..V_TOTAL-1
//                pixel_column out  12-bit pixel counter, 0..H_TOTAL-1
//                pix_tick     out  high in the clock a new pixel is presented
//                line_start   out  pulse with the tick presenting column 0
//                frame_start  out  pulse with the tick presenting (0,0)
//  Config      : VGA_SYNC_DELAY_EN - when defined, both syncs pass through a
//                SYNC_DELAY-deep shift register (stages reset inactive) so
//                they line up with the registered colorizer output.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter logic        SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int unsigned CLK_DIV    = VGA_CLK_DIV,
    parameter int unsigned SYNC_DELAY = VGA_SYNC_DELAY
) (
    input  logic        clock,
    input  logic        reset,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        video_on,
    output logic [11:0] pixel_row,
    output logic [11:0] pixel_column,
    output logic        pix_tick,
    output logic        line_start,
    output logic        frame_start
);

    localparam coord_t C_H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t C_V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t C_H_ACTIVE = coord_t'(H_ACTIVE);
    localparam coord_t C_V_ACTIVE = coord_t'(V_ACTIVE);
    localparam coord_t C_HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t C_HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t C_VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t C_VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_SYNC_DELAY_EN
    localparam int unsigned C_SYNC_STAGES = SYNC_DELAY;
`else
    localparam int unsigned C_SYNC_STAGES = 0;
`endif

    logic   w_tick;
    coord_t r_h;
    coord_t r_v;
    // Marks the clock right after the counters moved, so the output
    // registers can flag the first clock that shows the new pixel.
    logic   r_adv;

    vga_pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .clk    (clock),
        .rst    (reset),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h   <= '0;
            r_v   <= '0;
            r_adv <= 1'b0;
        end else begin
            r_adv <= w_tick;
            if (w_tick) begin
                if (r_h == C_H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == C_V_LAST) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode and output registers
    // ------------------------------------------------------------------
    logic w_video_on;
    logic w_hs_win;
    logic w_vs_win;
    logic w_line_start;
    logic w_frame_start;

    assign w_video_on    = (r_h < C_H_ACTIVE) && (r_v < C_V_ACTIVE);
    assign w_hs_win      = (r_h >= C_HS_FIRST) && (r_h <= C_HS_LAST);
    assign w_vs_win      = (r_v >= C_VS_FIRST) && (r_v <= C_VS_LAST);
    // r_adv is clear after reset, so the implicit (0,0) never pulses.
    assign w_line_start  = r_adv && (r_h == '0);
    assign w_frame_start = r_adv && (r_h == '0) && (r_v == '0);

    logic r_hs;
    logic r_vs;

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_row    <= '0;
            pixel_column <= '0;
            video_on     <= 1'b0;
            pix_tick     <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            r_hs         <= ~SYNC_POL;
            r_vs         <= ~SYNC_POL;
        end else begin
            pixel_row    <= r_v;
            pixel_column <= r_h;
            video_on     <= w_video_on;
            pix_tick     <= r_adv;
            line_start   <= w_line_start;
            frame_start  <= w_frame_start;
            r_hs         <= w_hs_win ? SYNC_POL : ~SYNC_POL;
            r_vs         <= w_vs_win ? SYNC_POL : ~SYNC_POL;
        end
    end

    // ------------------------------------------------------------------
    // Optional sync alignment delay
    // ------------------------------------------------------------------
    generate
        if (C_SYNC_STAGES > 0) begin : g_sync_pipe
            logic [C_SYNC_STAGES-1:0] r_hs_pipe;
            logic [C_SYNC_STAGES-1:0] r_vs_pipe;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_hs_pipe <= {C_SYNC_STAGES{~SYNC_POL}};
                    r_vs_pipe <= {C_SYNC_STAGES{~SYNC_POL}};
                end else begin
                    r_hs_pipe[0] <= r_hs;
                    r_vs_pipe[0] <= r_vs;
                    for (int i = 1; i < int'(C_SYNC_STAGES); i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                    end
                end
            end

            assign horiz_sync = r_hs_pipe[C_SYNC_STAGES-1];
            assign vert_sync  = r_vs_pipe[C_SYNC_STAGES-1];
        end else begin : g_sync_direct
            assign horiz_sync = r_hs;
            assign vert_sync  = r_vs;
        end
    endgenerate

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed bench. Instance A uses the default 640x480 timing,
//                instance B the scaled 14x7 raster with CLK_DIV=1 and
//                active-high syncs. Expected values come from closed-form
//                raster arithmetic on the clock count since reset release.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        a_hs, a_vs, a_von, a_tick, a_ls, a_fs;
    logic [11:0] a_row, a_col;
    logic        b_hs, b_vs, b_von, b_tick, b_ls, b_fs;
    logic [11:0] b_row, b_col;

    vga_timing_gen u_dut_a (
        .clock        (clk),
        .reset        (rst_a),
        .horiz_sync   (a_hs),
        .vert_sync    (a_vs),
        .video_on     (a_von),
        .pixel_row    (a_row),
        .pixel_column (a_col),
        .pix_tick     (a_tick),
        .line_start   (a_ls),
        .frame_start  (a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b1), .CLK_DIV (1), .SYNC_DELAY (2)
    ) u_dut_b (
        .clock        (clk),
        .reset        (rst_b),
        .horiz_sync   (b_hs),
        .vert_sync    (b_vs),
        .video_on     (b_von),
        .pixel_row    (b_row),
        .pixel_column (b_col),
        .pix_tick     (b_tick),
        .line_start   (b_ls),
        .frame_start  (b_fs)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Default raster: pixel index = clocks since release / 4, active-low syncs
    function automatic logic a_hs_exp(input int idx);
        int col;
        if (idx < 0) return 1'b1;
        col = (idx / 4) % 800;
        return !(col >= 656 && col <= 751);
    endfunction

    function automatic logic a_vs_exp(input int idx);
        int row;
        if (idx < 0) return 1'b1;
        row = ((idx / 4) / 800) % 525;
        return !(row >= 490 && row <= 491);
    endfunction

    // Scaled raster: 14 columns x 7 rows, one pixel per clock, active-high syncs
    function automatic logic b_hs_exp(input int idx);
        int col;
        if (idx < 0) return 1'b0;
        col = idx % 14;
        return (col >= 10 && col <= 11);
    endfunction

    function automatic logic b_vs_exp(input int idx);
        int row;
        if (idx < 0) return 1'b0;
        row = (idx / 14) % 7;
        return (row == 5);
    endfunction

    int pix, col, row;
    int hs_low_clks;
    int von_cnt, ls_cnt, fs_cnt, last_fs;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // ---- reset values ----
        chk("a_rst_row",  32'(a_row), 0);
        chk("a_rst_col",  32'(a_col), 0);
        chk("a_rst_von",  32'(a_von), 0);
        chk("a_rst_tick", 32'(a_tick), 0);
        chk("a_rst_ls",   32'(a_ls), 0);
        chk("a_rst_fs",   32'(a_fs), 0);
        chk("a_rst_hs",   32'(a_hs), 1);
        chk("a_rst_vs",   32'(a_vs), 1);
        chk("b_rst_hs",   32'(b_hs), 0);
        chk("b_rst_vs",   32'(b_vs), 0);

        // ---- default timing: first line and wrap into row 1 ----
        @(negedge clk);
        rst_a = 1'b0;
        hs_low_clks = 0;
        for (int n = 0; n <= 3300; n++) begin
            @(posedge clk);
            #1;
            pix = n / 4;
            col = pix % 800;
            row = (pix / 800) % 525;
            chk("a_col",  32'(a_col), 32'(col));
            chk("a_row",  32'(a_row), 32'(row));
            chk("a_tick", 32'(a_tick), 32'(n > 0 && n % 4 == 0));
            chk("a_ls",   32'(a_ls), 32'(n > 0 && n % 4 == 0 && col == 0));
            chk("a_fs",   32'(a_fs), 32'(n > 0 && n % 4 == 0 && col == 0 && row == 0));
            chk("a_von",  32'(a_von), 32'(col < 640 && row < 480));
            chk("a_hs",   32'(a_hs), 32'(a_hs_exp(n - LAT)));
            chk("a_vs",   32'(a_vs), 32'(a_vs_exp(n - LAT)));
            if (n >= 1 && n <= 3199 && a_hs == 1'b0) hs_low_clks++;
        end
        // 96 pixels of 4 clocks each
        chk("a_hs_low_clocks", 32'(hs_low_clks), 384);

        // ---- mid-frame reset at row 1, column 300 ----
        for (int n = 3301; n <= 4400; n++) @(posedge clk);
        #1;
        chk("a_pre_rst_col", 32'(a_col), 300);
        chk("a_pre_rst_row", 32'(a_row), 1);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        chk("a_mid_row",  32'(a_row), 0);
        chk("a_mid_col",  32'(a_col), 0);
        chk("a_mid_von",  32'(a_von), 0);
        chk("a_mid_tick", 32'(a_tick), 0);
        chk("a_mid_ls",   32'(a_ls), 0);
        chk("a_mid_fs",   32'(a_fs), 0);
        chk("a_mid_hs",   32'(a_hs), 1);
        chk("a_mid_vs",   32'(a_vs), 1);
        @(negedge clk);
        rst_a = 1'b0;
        for (int n = 0; n <= 8; n++) begin
            @(posedge clk);
            #1;
            chk("a_rel_col",  32'(a_col), 32'(n / 4));
            chk("a_rel_row",  32'(a_row), 0);
            chk("a_rel_tick", 32'(a_tick), 32'(n > 0 && n % 4 == 0));
            chk("a_rel_ls",   32'(a_ls), 0);
            chk("a_rel_fs",   32'(a_fs), 0);
        end

        // ---- scaled build: two full frames ----
        von_cnt = 0;
        ls_cnt  = 0;
        fs_cnt  = 0;
        last_fs = -1;
        @(negedge clk);
        rst_b = 1'b0;
        for (int n = 0; n <= 200; n++) begin
            @(posedge clk);
            #1;
            col = n % 14;
            row = (n / 14) % 7;
            chk("b_col",  32'(b_col), 32'(col));
            chk("b_row",  32'(b_row), 32'(row));
            chk("b_tick", 32'(b_tick), 32'(n > 0));
            chk("b_von",  32'(b_von), 32'(col < 8 && row < 4));
            chk("b_ls",   32'(b_ls), 32'(n > 0 && col == 0));
            chk("b_fs",   32'(b_fs), 32'(n > 0 && col == 0 && row == 0));
            chk("b_hs",   32'(b_hs), 32'(b_hs_exp(n - LAT)));
            chk("b_vs",   32'(b_vs), 32'(b_vs_exp(n - LAT)));
            if (n >= 1 && n <= 98 && b_von) von_cnt++;
            if (n >= 1 && n <= 98 && b_ls) ls_cnt++;
            if (n >= 1 && n <= 196 && b_fs) begin
                if (last_fs >= 0) chk("b_frame_period", 32'(n - last_fs), 98);
                last_fs = n;
                fs_cnt++;
            end
        end
        chk("b_von_per_frame",  32'(von_cnt), 32);
        chk("b_ls_per_frame",   32'(ls_cnt), 7);
        chk("b_fs_two_frames",  32'(fs_cnt), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
